// File: rtl/arbiter_rr_ctrl_pkg.sv
// Shared constants, FSM state type and index-width helper for the round-robin arbiter.
package arb_pkg;

  localparam int ARB_N        = 5;
  localparam int ARB_MAX_HOLD = 4;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arbiter_rr_ctrl_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping.
module arb_rr_pick
  import arb_pkg::*;
#(
  parameter int N = ARB_N,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] win_id,
  output logic          win_valid
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;

  // Lower copy masked below ptr, upper copy intact: the lowest set bit is the
  // first requester in wrap-around order starting at ptr.
  always_comb begin
    dbl       = {req, req};
    masked    = dbl & ({(2*N){1'b1}} << ptr);
    win       = '0;
    win_id    = '0;
    win_valid = 1'b0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (masked[i]) begin
        win_valid = 1'b1;
        win_id    = IW'(i % N);
      end
    end
    if (win_valid) win[win_id] = 1'b1;
  end

endmodule

// File: rtl/arbiter_rr_ctrl.sv
// N-way round-robin arbiter with registered one-hot grant.
// Define ARB_HOLD_EN to let a winner keep the grant for up to MAX_HOLD cycles.
module arbiter_rr_ctrl
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int MAX_HOLD = ARB_MAX_HOLD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [idx_w(N)-1:0]  gnt_id
);

  localparam int IW = idx_w(N);

  if (N < 2 || N > 16) begin : g_chk_n
    $error("arbiter_rr_ctrl: N out of range 2..16");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_chk_hold
    $error("arbiter_rr_ctrl: MAX_HOLD out of range 1..15");
  end

  arb_state_t    state, state_nxt;
  logic [IW-1:0] ptr, ptr_nxt;
  logic [N-1:0]  gnt_nxt;
  logic [IW-1:0] gnt_id_nxt;
  logic [N-1:0]  win;
  logic [IW-1:0] win_id;
  logic          win_valid;
  logic          hold_take;

`ifdef ARB_HOLD_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_cnt, hold_nxt;
  assign hold_take = (state == ARB_GRANT) && req[gnt_id] &&
                     (hold_cnt < HW'(MAX_HOLD - 1));
`else
  assign hold_take = 1'b0;
`endif

  arb_rr_pick #(.N(N)) u_pick (
    .req       (req),
    .ptr       (ptr),
    .win       (win),
    .win_id    (win_id),
    .win_valid (win_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ARB_IDLE;
      ptr    <= '0;
      gnt    <= '0;
      gnt_id <= '0;
`ifdef ARB_HOLD_EN
      hold_cnt <= '0;
`endif
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      gnt    <= gnt_nxt;
      gnt_id <= gnt_id_nxt;
`ifdef ARB_HOLD_EN
      hold_cnt <= hold_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:  if (win_valid) state_nxt = ARB_GRANT;
      ARB_GRANT: if (!hold_take && !win_valid) state_nxt = ARB_IDLE;
      default:   state_nxt = ARB_IDLE;
    endcase
  end

  // A held grant freezes grant, id and pointer; otherwise follow the picker.
  always_comb begin
    gnt_nxt    = win;
    gnt_id_nxt = win_id;
    ptr_nxt    = ptr;
    if (win_valid) ptr_nxt = (win_id == IW'(N - 1)) ? '0 : win_id + 1'b1;
`ifdef ARB_HOLD_EN
    hold_nxt = '0;
`endif
    if (hold_take) begin
      gnt_nxt    = gnt;
      gnt_id_nxt = gnt_id;
      ptr_nxt    = ptr;
`ifdef ARB_HOLD_EN
      hold_nxt   = hold_cnt + 1'b1;
`endif
    end
  end

  assign gnt_valid = (state == ARB_GRANT);

endmodule

// File: tb/tb_arbiter_rr_ctrl.sv
// Self-checking bench for arbiter_rr_ctrl: directed scenarios plus randomized traffic vs a reference model.
module tb_arbiter_rr_ctrl;

  localparam int N        = 5;
  localparam int MAX_HOLD = 4;
  localparam int IW       = 3;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic          gnt_valid;
  logic [IW-1:0] gnt_id;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  int           m_ptr;
  logic [N-1:0] m_gnt;
  int           m_id;
  int           m_hold;
  bit           m_busy;

  arbiter_rr_ctrl #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    m_ptr  = 0;
    m_gnt  = '0;
    m_id   = 0;
    m_hold = 0;
    m_busy = 0;
  endfunction

  function automatic void model_step(input logic [N-1:0] r);
    int w;
`ifdef ARB_HOLD_EN
    if (m_busy && r[m_id] && m_hold < MAX_HOLD - 1) begin
      m_hold = m_hold + 1;
      return;
    end
`endif
    w = -1;
    for (int k = 0; k < N; k++)
      if (w < 0 && r[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    m_hold = 0;
    if (w >= 0) begin
      m_gnt  = N'(1) << w;
      m_id   = w;
      m_ptr  = (w + 1) % N;
      m_busy = 1;
    end else begin
      m_gnt  = '0;
      m_id   = 0;
      m_busy = 0;
    end
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    req = 5'b11111;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (gnt !== 5'b0 || gnt_valid !== 1'b0 || gnt_id !== 3'd0) begin
        n_fail++;
        $display("FAIL reset_hold: gnt=%b vld=%b id=%0d, want 00000/0/0", gnt, gnt_valid, gnt_id);
      end
    end
    rst = 1'b1;
    req = '0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      model_step(req);
      n_cmp++;
      if (gnt !== 5'b0 || gnt_valid !== 1'b0 || gnt_id !== 3'd0) begin
        n_fail++;
        $display("FAIL idle_after_reset: gnt=%b vld=%b id=%0d, want 00000/0/0", gnt, gnt_valid, gnt_id);
      end
    end
  endtask

  task automatic test_contention();
    logic [N-1:0] exp;
    req = 5'b11111;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      model_step(req);
`ifdef ARB_HOLD_EN
      exp = m_gnt;
`else
      exp = N'(1) << (c % N);
`endif
      n_cmp++;
      if (gnt !== exp || gnt_valid !== 1'b1 || $countones(gnt) != 1) begin
        n_fail++;
        $display("FAIL contention[%0d]: gnt=%b vld=%b, want %b/1", c, gnt, gnt_valid, exp);
      end
    end
  endtask

  task automatic test_wrap_skip();
    logic [N-1:0] seq_req [3];
    logic [N-1:0] seq_exp [3];
    seq_req[0] = 5'b00100; seq_exp[0] = 5'b00100;
    seq_req[1] = 5'b00101; seq_exp[1] = 5'b00001;
    seq_req[2] = 5'b00101; seq_exp[2] = 5'b00100;
    for (int c = 0; c < 3; c++) begin
      req = seq_req[c];
      @(posedge clk); #1;
      model_step(req);
`ifdef ARB_HOLD_EN
      seq_exp[c] = m_gnt;
`endif
      n_cmp++;
      if (gnt !== seq_exp[c] || gnt_id !== IW'(m_id)) begin
        n_fail++;
        $display("FAIL wrap_skip[%0d]: gnt=%b id=%0d, want %b id=%0d", c, gnt, gnt_id, seq_exp[c], m_id);
      end
    end
  endtask

  task automatic test_drop();
    req = '0;
    @(posedge clk); #1;
    model_step(req);
    n_cmp++;
    if (gnt !== 5'b0 || gnt_valid !== 1'b0 || gnt_id !== 3'd0) begin
      n_fail++;
      $display("FAIL drop: gnt=%b vld=%b id=%0d, want 00000/0/0", gnt, gnt_valid, gnt_id);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] prev;
    prev = req;
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 3))
        0:       req = N'($urandom);
        1:       req = N'($urandom) & N'($urandom);
        2:       req = prev;
        default: req = '0;
      endcase
      @(posedge clk); #1;
      model_step(req);
      n_cmp++;
      if (gnt !== m_gnt || gnt_valid !== m_busy || gnt_id !== IW'(m_id) ||
          (gnt & ~req) != '0) begin
        n_fail++;
        $display("FAIL random[%0d]: req=%b gnt=%b vld=%b id=%0d, want gnt=%b vld=%b id=%0d",
                 c, req, gnt, gnt_valid, gnt_id, m_gnt, m_busy, m_id);
      end
      prev = req;
    end
  endtask

  task automatic test_async_reset();
    req = 5'b01000;
    @(posedge clk); #1;
    model_step(req);
    n_cmp++;
    if (gnt !== 5'b01000) begin
      n_fail++;
      $display("FAIL pre_async_grant: gnt=%b, want 01000", gnt);
    end
    #2 rst = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (gnt !== 5'b0 || gnt_valid !== 1'b0 || gnt_id !== 3'd0) begin
      n_fail++;
      $display("FAIL async_clear: gnt=%b vld=%b id=%0d, want 00000/0/0", gnt, gnt_valid, gnt_id);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    req = 5'b11000;
    @(posedge clk); #1;
    model_step(req);
    n_cmp++;
    if (gnt !== 5'b01000 || gnt_id !== 3'd3 || gnt_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_ptr0: gnt=%b id=%0d vld=%b, want 01000 id=3 vld=1", gnt, gnt_id, gnt_valid);
    end
  endtask

`ifdef ARB_HOLD_EN
  task automatic test_hold();
    logic [N-1:0] exp;
    @(posedge clk); #1;
    rst = 1'b0;
    #1 rst = 1'b1;
    model_reset();
    req = 5'b00011;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      model_step(req);
      exp = ((c / MAX_HOLD) % 2) ? 5'b00010 : 5'b00001;
      n_cmp++;
      if (gnt !== exp) begin
        n_fail++;
        $display("FAIL hold[%0d]: gnt=%b, want %b", c, gnt, exp);
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b0;
    req = '0;
    test_reset();
    test_contention();
    test_wrap_skip();
    test_drop();
    test_random();
    test_async_reset();
`ifdef ARB_HOLD_EN
    test_hold();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/arbiter_rr_ctrl.md
# arbiter_rr_ctrl

Five-way round-robin arbiter that shares a single downstream resource between requesters. Each cycle it samples the `req` vector and registers a one-hot (or zero) `gnt` vector one cycle later. Rotating priority guarantees fairness. An optional hold mode lets a winner keep the resource for a bounded burst. The block is the design counterpart of the team's arbiter property set: single grant, and every grant backed by a request in the previous cycle.

## Interface
- `N`, 5: number of requesters; legal range 2–16.
- `MAX_HOLD`, 4: maximum consecutive grant cycles per winner. Used only with `ARB_HOLD_EN`; legal range 1–15.
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: reset, asynchronous assert, active-low (0 = reset).
- `req`, input, N: request vector; bit i high means requester i wants the resource.
- `gnt`, output, N: registered grant vector; one-hot or all-zero.
- `gnt_valid`, output, 1: OR of `gnt`.
- `gnt_id`, output, $clog2(N): index of the granted requester; 0 when `gnt_valid` is 0.

## Operation
- Priority pointer `ptr` (0..N-1) names the highest-priority requester.
- Search order is ptr, ptr+1, …, N-1, 0, …, ptr-1, with wrap-around modulo N.
- The winner is the first index in search order with `req[i]` = 1. If no bit is set, there is no winner.
- State machine (two states):
  - IDLE: `gnt` = 0. On the next edge, a winner w gives `gnt` = 1<<w and the state moves to GRANT. No winner means stay in IDLE.
  - GRANT (holder h): re-arbitrate every cycle from the current `req`.
    - Winner found: grant it, stay in GRANT.
    - No winner: return to IDLE.
- Pointer update:
  - When a grant is issued to w, `ptr` becomes (w+1) mod N. With N=5, w=4 gives `ptr` = 0.
  - `ptr` is unchanged while there is no winner.
- Simultaneous requests resolve only by rotating priority. No requester ever wins twice in a row while another requester is continuously requesting, except under hold mode.
- Grant correctness invariant: `gnt[i]` = 1 at cycle t implies `req[i]` = 1 at cycle t-1.
- Reset values: `gnt` = 0, `gnt_valid` = 0, `gnt_id` = 0, `ptr` = 0, state IDLE, hold counter 0.
- Reset mid-grant clears `gnt` asynchronously in the same cycle. After `rst` is released, the first arbitration happens at the first rising edge and uses `ptr` = 0.

## Timing
- Latency from `req` to `gnt` is exactly 1 cycle; the grant is registered with no combinational path from `req`.
- `gnt_id` and `gnt_valid` are derived from registered state and are glitch-free.
- Dropping `req[h]` removes `gnt[h]` on the next edge.
- Throughput: a new grant is possible every cycle. Back-to-back grants to different requesters need no idle cycle.

## Configuration
- `ARB_HOLD_EN` defined (hold mode):
  - In GRANT with holder h, if `req[h]` = 1 and `hold_cnt` < MAX_HOLD-1, `gnt` stays 1<<h, `hold_cnt` increments, and `ptr` is frozen.
  - Otherwise the block re-arbitrates normally and `hold_cnt` resets to 0 on every new grant.
  - `hold_cnt` width is $clog2(MAX_HOLD+1).
  - A holder is therefore granted for at most MAX_HOLD consecutive cycles whenever another requester is pending.
- `ARB_HOLD_EN` not defined: no hold counter exists, and the block re-arbitrates every cycle as described in Operation.

## Structure
- Package `arb_pkg`:
  - default `N` and `MAX_HOLD` constants;
  - state enum `arb_state_t` {ARB_IDLE, ARB_GRANT};
  - a helper function returning the index width.
- Sub-module `arb_rr_pick`: purely combinational rotating-priority picker.
  - Inputs: `req`, `ptr`.
  - Outputs: one-hot `win`, `win_id`, `win_valid`.
  - Implemented with the double-width masked priority encode.
- The top level holds the registers, the FSM, the pointer and the hold counter.

## Test plan
- Reset then idle: `rst`=0 for 3 cycles with `req`=5'b11111 → `gnt`=0. Release with `req`=0 → `gnt` stays 0 and `gnt_valid`=0.
- Full contention, hold mode off: `req`=5'b11111 held for 10 cycles → `gnt` sequence 00001, 00010, 00100, 01000, 10000, 00001, … with one-cycle latency, always one-hot.
- Wrap and skip: `ptr`=3 after a grant to 2, then `req`=5'b00101 → `gnt`=00001 next cycle, `ptr`=1; then `req` unchanged → `gnt`=00100.
- Request drop: `gnt`=00100 and `req` drops to 0 → next cycle `gnt`=0 and the state is IDLE.
- Hold mode (`ARB_HOLD_EN`, `MAX_HOLD`=4): `req`=5'b00011 held → `gnt[0]` for 4 cycles, then `gnt[1]` for 4 cycles, repeating.
- Async reset mid-grant: assert `rst`=0 between edges while `gnt`=01000 → `gnt` goes to 0 immediately. After release with `req`=5'b11000 → `gnt`=01000 (`ptr` = 0 after reset, so index 3 wins).
